// File: rtl/riscv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divide ops return err.
module riscv_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            err,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     result_q;
  logic                err_q;
  logic                spec_q;
  logic [2:0]          op_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opb_q;
  logic                neg_q;

  logic                accept;
  logic                a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                spec_d;
  logic [XLEN-1:0]     spec_res_d;
  logic                spec_err_d;
  logic [2*XLEN-1:0]   acc_d;
  logic [XLEN-1:0]     result_d;

  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   mc);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mc} : '0);
    return {sum, acc[XLEN-1:1]};
  endfunction

  assign accept    = (state_q == IDLE) && in_valid && !flush;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;

  // DIV/REM and MULH/MULHSU treat rs1 as signed; only DIV/REM and MULH treat rs2 as signed
  assign a_sgn = op[2] ? !op[0] : (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
  assign b_sgn = op[2] ? !op[0] : (op[1:0] == 2'b01);
  assign a_neg = a_sgn && a[XLEN-1];
  assign b_neg = b_sgn && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic neg_rem_q;
  logic b_zero, ovf;

  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   dv);
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
    sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = sh - {1'b0, dv};
    if (!diff[XLEN]) return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    return {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  endfunction

  assign b_zero     = (b == '0);
  assign ovf        = (a == SMIN) && (b == '1) && !op[0];
  assign spec_d     = op[2] && (b_zero || ovf);
  assign spec_res_d = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  assign spec_err_d = 1'b0;
  assign acc_d      = op_q[2] ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);

  always_comb begin
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r;
    p = neg_q ? -acc_q : acc_q;
    q = acc_q[XLEN-1:0];
    r = acc_q[2*XLEN-1:XLEN];
    result_d = '0;
    if (op_q[2])
      result_d = op_q[1] ? (neg_rem_q ? -r : r) : (neg_q ? -q : q);
    else
      result_d = (op_q[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (accept) neg_rem_q <= a_neg;
  end
`else
  assign spec_d     = op[2];
  assign spec_res_d = '1;
  assign spec_err_d = 1'b1;
  assign acc_d      = mul_step(acc_q, opb_q);

  always_comb begin
    logic [2*XLEN-1:0] p;
    p = neg_q ? -acc_q : acc_q;
    result_d = (op_q[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  end
`endif

  // Operand/accumulator datapath: low half starts as multiplier or dividend, high half as 0
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op;
      acc_q <= {{XLEN{1'b0}}, a_mag};
      opb_q <= b_mag;
      neg_q <= a_neg ^ b_neg;
    end else if (state_q == BUSY && !spec_q && cnt_q != LAST) begin
      acc_q <= acc_d;
    end
  end

  // Control FSM; special cases (div by zero, overflow, disabled divide) skip iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      spec_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            spec_q  <= spec_d;
            if (spec_d) begin
              result_q <= spec_res_d;
              err_q    <= spec_err_d;
            end
          end
        end
        BUSY: begin
          if (spec_q) begin
            state_q <= DONE;
          end else if (cnt_q == LAST) begin
            result_q <= result_d;
            err_q    <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_iter.sv
// Directed-vector bench for riscv_muldiv_iter (XLEN=32); expectations follow MULDIV_DIV_EN.
module tb_riscv_muldiv_iter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'b000;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            err;
  logic            busy;

  int checks = 0;
  int errors = 0;

  riscv_muldiv_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, measure accept-to-out_valid edges, check the result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic ee,
                        input int el);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_lat"}, n, el);
    check({tag, "_res"}, result, er);
    check({tag, "_err"}, err, ee);
    if (out_ready) begin
      @(posedge clk);
      #1 check({tag, "_idle"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    int  seen;
    logic [2:0] long_op;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, '0);
    check("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_30x7", 3'b000, 32'd30, 32'd7, 32'd210, 1'b0, XLEN + 1);
    run_op("mulh_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, XLEN + 1);
    run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, XLEN + 1);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, XLEN + 1);
    run_op("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, XLEN + 1);
    run_op("mulh_big", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, XLEN + 1);

`ifdef MULDIV_DIV_EN
    run_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, XLEN + 1);
    run_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, XLEN + 1);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, XLEN + 1);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, XLEN + 1);
    run_op("divu_7_0", 3'b101, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
    run_op("rem_7_0", 3'b110, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    long_op = 3'b100;
`else
    run_op("divu_nodiv", 3'b101, 32'd9, 32'd3, 32'hFFFFFFFF, 1'b1, 1);
    run_op("rem_nodiv", 3'b110, 32'd5, 32'd2, 32'hFFFFFFFF, 1'b1, 1);
    long_op = 3'b011;
`endif
    run_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0, XLEN + 1);

    // Consumer stall in DONE
    out_ready = 1'b0;
    run_op("mul_stall", 3'b000, 32'd10, 32'd20, 32'd200, 1'b0, XLEN + 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_res", result, 32'd200);
      check("stall_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_idle", in_ready, 1'b1);
    check("stall_release_valid", out_valid, 1'b0);

    // Flush 10 cycles into a long operation
    @(negedge clk);
    op = long_op; a = 32'hFFFFFF9C; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 seen |= int'(out_valid);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_idle", in_ready, 1'b1);
    check("flush_busy", busy, 1'b0);
    flush = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= int'(out_valid);
    end
    check("flush_no_valid", seen, 0);
    run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, XLEN + 1);

    // Flush wins against a simultaneous request
    @(negedge clk);
    op = 3'b000; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept_busy", busy, 1'b0);
    check("flush_vs_accept_ready", in_ready, 1'b1);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_5x5", 3'b000, 32'd5, 32'd5, 32'd25, 1'b0, XLEN + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
